// File: rtl/ddr_native_wr_ctrl_pkg.sv
// ddr_wr_pkg: shared state encoding and MIG constants for the native write controller
package ddr_wr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2, HOLD = 2'd3} wr_state_e;
  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam int ADDR_STEP_DEF = 8;
endpackage

// File: rtl/ddr_native_wr_ctrl_if.sv
// ddr_native_wr_ctrl_if: MIG native app write command + write-data channels
interface ddr_native_wr_ctrl_if #(
  parameter int DDR_DATA_WD = 512,
  parameter int APP_ADDR_WD = 28
);
  logic                     app_en;
  logic [2:0]               app_cmd;
  logic [APP_ADDR_WD-1:0]   app_addr;
  logic                     app_rdy;
  logic                     app_wdf_wren;
  logic                     app_wdf_end;
  logic [DDR_DATA_WD-1:0]   app_wdf_data;
  logic [DDR_DATA_WD/8-1:0] app_wdf_mask;
  logic                     app_wdf_rdy;
  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    input  app_rdy, app_wdf_rdy
  );
  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/ddr_native_wr_ctrl_sat_cnt.sv
// ddr_sat_cnt: saturating up-counter with synchronous clear (clear wins over increment)
module ddr_sat_cnt #(
  parameter int WD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [WD-1:0] cnt_o
);
  logic [WD-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i) ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ddr_native_wr_ctrl.sv
// ddr_native_wr_ctrl: burst-to-MIG native write engine; DDR_NATIVE_WR_DBGCNT_EN adds debug counters
module ddr_native_wr_ctrl
  import ddr_wr_pkg::*;
#(
  parameter int DDR_DATA_WD   = 512,
  parameter int BURST_ADDR_WD = 64,
  parameter int APP_ADDR_WD   = 28,
  parameter int ADDR_STEP     = ADDR_STEP_DEF,
  parameter int LEN_WD        = 10,
  parameter int DGBCNT_WD     = 16
) (
  input  logic                     ddr_clk,
  input  logic                     ddr_rst,
  input  logic                     wr_burst_req,
  input  logic [LEN_WD-1:0]        wr_burst_len,
  input  logic [BURST_ADDR_WD-1:0] wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [DDR_DATA_WD-1:0]   wr_burst_data,
  output logic                     wr_burst_finish,
`ifdef DDR_NATIVE_WR_DBGCNT_EN
  input  logic                     dbg_cnt_clr,
  output logic [DGBCNT_WD-1:0]     dbg_burst_cnt,
  output logic [DGBCNT_WD-1:0]     dbg_stall_cnt,
`endif
  ddr_native_wr_ctrl_if.master     app
);
  wr_state_e              state_q, state_d;
  logic [LEN_WD-1:0]      len_q, len_d, cmd_cnt_q, cmd_cnt_d, dat_cnt_q, dat_cnt_d;
  logic [APP_ADDR_WD-1:0] addr_q, addr_d;
  logic                   cmd_go, dat_go, unused_addr_hi;
  assign unused_addr_hi = ^wr_burst_addr[BURST_ADDR_WD-1:APP_ADDR_WD];
  assign app.app_en     = (state_q == WRITE) && (cmd_cnt_q < len_q);
  assign cmd_go         = app.app_en && app.app_rdy;
  assign dat_go         = (state_q == WRITE) && (dat_cnt_q < len_q) && app.app_wdf_rdy;
  assign app.app_cmd      = APP_CMD_WR;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_wren = dat_go;
  assign app.app_wdf_end  = dat_go;
  assign app.app_wdf_data = dat_go ? wr_burst_data : '0;
  assign app.app_wdf_mask = '0;
  assign wr_burst_data_req = dat_go;
  assign wr_burst_finish   = (state_q == DONE);
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = cmd_go ? addr_q + APP_ADDR_WD'(ADDR_STEP) : addr_q;
    cmd_cnt_d = cmd_cnt_q + LEN_WD'(cmd_go);
    dat_cnt_d = dat_cnt_q + LEN_WD'(dat_go);
    case (state_q)
      IDLE: if (wr_burst_req) begin
        len_d     = wr_burst_len;
        addr_d    = wr_burst_addr[APP_ADDR_WD-1:0];
        cmd_cnt_d = '0;
        dat_cnt_d = '0;
        state_d   = (wr_burst_len == '0) ? DONE : WRITE;
      end
      WRITE: state_d = (cmd_cnt_q == len_q && dat_cnt_q == len_q) ? DONE : WRITE;
      DONE:  state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      cmd_cnt_q <= cmd_cnt_d;
      dat_cnt_q <= dat_cnt_d;
    end
  end
`ifdef DDR_NATIVE_WR_DBGCNT_EN
  ddr_sat_cnt #(.WD(DGBCNT_WD)) u_burst_cnt (
    .clk(ddr_clk), .rst(ddr_rst), .clr_i(dbg_cnt_clr), .inc_i(wr_burst_finish), .cnt_o(dbg_burst_cnt)
  );
  ddr_sat_cnt #(.WD(DGBCNT_WD)) u_stall_cnt (
    .clk(ddr_clk), .rst(ddr_rst), .clr_i(dbg_cnt_clr), .inc_i(app.app_en && !app.app_rdy), .cnt_o(dbg_stall_cnt)
  );
`endif
endmodule
